rshift_iter: RTL and testbench

Iterative 32-bit right shifter for the MultDiv unit, the right-shift counterpart to the single-bit left shifter. It latches an operand and shift amount on a start pulse, then shifts right by one bit per clock, logically or arithmetically, until the requested amount is consumed. It raises a one-cycle result-ready strobe, matching the multi-cycle handshake the multiplier and divider use toward the pipeline. The divider reuses it for quotient/remainder realignment.

---
 rtl/rshift_iter.sv | 104 ++++++++++
 tb/tb_rshift_iter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rshift_iter.sv
// rshift_iter: iterative 32-bit right shifter for the MultDiv unit.
// Latches operand, shift amount and mode on an accepted start, then shifts
// right one bit per clock (zero-fill or sign-fill) until the amount is used up,
// and strobes data_resultRDY for one cycle when the result is final.
// Optional feature macro: RSHIFT_FAST4_EN -- while at least 4 bits of shift
// remain, each SHIFT cycle moves 4 bits instead of 1.
module rshift_iter (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_start,
    input  logic        ctrl_arith,
    input  logic [31:0] data_operandA,
    input  logic [4:0]  ctrl_shiftamt,
    output logic [31:0] data_result,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  count;
    logic [4:0]  count_next;
    logic [31:0] result_next;
    logic        arith_q;
    logic        arith_next;
    logic        fill;

    // Fill bit entering from the top: sign bit in arithmetic mode, else zero.
    assign fill = arith_q & data_result[31];

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next  = state;
        count_next  = count;
        result_next = data_result;
        arith_next  = arith_q;

        case (state)
            IDLE, DONE: begin
                if (ctrl_start) begin
                    result_next = data_operandA;
                    count_next  = ctrl_shiftamt;
                    arith_next  = ctrl_arith;
                    state_next  = (ctrl_shiftamt == 5'd0) ? DONE : SHIFT;
                end else begin
                    state_next  = IDLE;
                end
            end

            SHIFT: begin
`ifdef RSHIFT_FAST4_EN
                if (count >= 5'd4) begin
                    result_next = {{4{fill}}, data_result[31:4]};
                    count_next  = count - 5'd4;
                end else begin
                    result_next = {fill, data_result[31:1]};
                    count_next  = count - 5'd1;
                end
`else
                result_next = {fill, data_result[31:1]};
                count_next  = count - 5'd1;
`endif
                // Start requests are ignored here; only the counter decides.
                state_next = (count_next == 5'd0) ? DONE : SHIFT;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counter, mode and working register; synchronous reset wins.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset) begin
            // NOTE: reset is synchronous and active-high here; it aborts any
            // operation in flight, so no ready strobe follows it.
            state       <= IDLE;
            count       <= 5'd0;
            data_result <= 32'd0;
            arith_q     <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            data_result <= result_next;
            arith_q     <= arith_next;
        end
    end

    // Handshake outputs decoded from the registered state only.
    assign data_resultRDY = (state == DONE);
    assign busy           = (state == SHIFT);

endmodule

// File: tb/tb_rshift_iter.sv
// tb_rshift_iter: self-checking bench for rshift_iter.
// A cycle-level reference (start edge, latency, expected value) is checked
// against busy / data_resultRDY / data_result every cycle, while directed
// tests pin literal results and latencies.
module tb_rshift_iter;

`ifdef RSHIFT_FAST4_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        ctrl_start;
    logic        ctrl_arith;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    rshift_iter dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .ctrl_arith     (ctrl_arith),
        .data_operandA  (data_operandA),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules: result and latency straight from the arithmetic.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int n, input bit ar);
        logic signed [31:0] s;
        s = a;
        if (ar) return s >>> n;
        return a >> n;
    endfunction

    function automatic int ref_lat(input int n);
        if (FAST) return n / 4 + n % 4;
        return n;
    endfunction

    // ---------------- cycle-level reference and compare process -------------
    // Cycle c is the interval following rising edge c.
    int          cyc       = 0;
    bit          armed     = 1'b0;
    bit          active    = 1'b0;
    bit          prev_busy = 1'b0;
    int          k_edge    = 0;
    int          lat       = 0;
    logic [31:0] exp_val   = 32'd0;

    always begin
        bit          s_rst, s_start, s_ar;
        logic [31:0] s_a;
        logic [4:0]  s_n;
        bit          e_busy, e_rdy;
        @(posedge clock);
        s_rst   = reset;
        s_start = ctrl_start;
        s_a     = data_operandA;
        s_n     = ctrl_shiftamt;
        s_ar    = ctrl_arith;
        cyc++;
        if (s_rst) begin
            armed     = 1'b1;
            active    = 1'b0;
            exp_val   = 32'd0;
            prev_busy = 1'b0;
        end else if (!prev_busy && s_start) begin
            active  = 1'b1;
            k_edge  = cyc;
            lat     = ref_lat(int'(s_n));
            exp_val = ref_shift(s_a, int'(s_n), s_ar);
        end
        #1;
        if (armed) begin
            e_busy = active && (cyc >= k_edge) && (cyc < k_edge + lat);
            e_rdy  = active && (cyc == k_edge + lat);
            check("busy", {31'd0, busy}, {31'd0, e_busy});
            check("rdy", {31'd0, data_resultRDY}, {31'd0, e_rdy});
            if (!e_busy) check("result", data_result, exp_val);
            prev_busy = e_busy;
        end
    end

    // ---------------- directed stimulus ----------------
    // Counts cycles (sampled mid-cycle) until ready, optionally scrambling inputs.
    task automatic wait_rdy(input bit noise, output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (!data_resultRDY && cycles < 40) begin
            if (busy) busy_cnt++;
            @(negedge clock);
            if (noise) begin
                data_operandA = $urandom;
                ctrl_shiftamt = 5'($urandom_range(0, 31));
                ctrl_arith    = 1'($urandom_range(0, 1));
            end
            cycles++;
        end
        if (!data_resultRDY) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: no data_resultRDY within 40 cycles at %0t", $time);
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [4:0] n,
                          input bit ar, input logic [31:0] exp, input int exp_lat,
                          input bit noise);
        int c, b;
        @(negedge clock);
        ctrl_start    = 1'b1;
        data_operandA = a;
        ctrl_shiftamt = n;
        ctrl_arith    = ar;
        @(negedge clock);
        ctrl_start = 1'b0;
        wait_rdy(noise, c, b);
        check({name, "_lat"}, c, exp_lat);
        check({name, "_busy_cycles"}, b, exp_lat);
        check({name, "_val"}, data_result, exp);
        @(negedge clock);
        check({name, "_rdy_width"}, {31'd0, data_resultRDY}, 32'd0);
        check({name, "_hold"}, data_result, exp);
    endtask

    initial begin
        int c, b;
        reset         = 1'b1;
        ctrl_start    = 1'b0;
        ctrl_arith    = 1'b0;
        data_operandA = 32'd0;
        ctrl_shiftamt = 5'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset_result", data_result, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);

        run_op("log31",   32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, FAST ? 10 : 31, 1'b0);
        run_op("ari31",   32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, FAST ? 10 : 31, 1'b0);
        run_op("ari4",    32'hF000_00F0, 5'd4,  1'b1, 32'hFF00_000F, FAST ? 1 : 4,   1'b0);
        run_op("log4",    32'hF000_00F0, 5'd4,  1'b0, 32'h0F00_000F, FAST ? 1 : 4,   1'b0);
        run_op("ari4pos", 32'h7000_0000, 5'd4,  1'b1, 32'h0700_0000, FAST ? 1 : 4,   1'b0);
        run_op("zero",    32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 0,              1'b0);
        run_op("log7",    32'hDEAD_BEEF, 5'd7,  1'b0, 32'h01BD_5B7D, FAST ? 4 : 7,   1'b0);

        // Start while busy is ignored; then a back-to-back start from DONE.
        @(negedge clock);
        ctrl_start    = 1'b1;
        data_operandA = 32'h0000_0100;
        ctrl_shiftamt = 5'd8;
        ctrl_arith    = 1'b0;
        @(negedge clock);
        ctrl_start = 1'b0;
        @(negedge clock);
        ctrl_start    = 1'b1;
        data_operandA = 32'hFFFF_FFFF;
        @(negedge clock);
        ctrl_start = 1'b0;
        wait_rdy(1'b0, c, b);
        check("busy_start_lat", c + 2, FAST ? 2 : 8);
        check("busy_start_val", data_result, 32'h0000_0001);
        ctrl_start    = 1'b1;
        data_operandA = 32'h0000_0010;
        ctrl_shiftamt = 5'd4;
        @(negedge clock);
        ctrl_start = 1'b0;
        wait_rdy(1'b0, c, b);
        check("b2b_lat", c, FAST ? 1 : 4);
        check("b2b_val", data_result, 32'h0000_0001);
        @(negedge clock);

        // Reset mid-operation aborts without a ready strobe.
        ctrl_start    = 1'b1;
        data_operandA = 32'hFFFF_0000;
        ctrl_shiftamt = 5'd16;
        ctrl_arith    = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_result", data_result, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        c = 0;
        for (int i = 0; i < 20; i++) begin
            if (data_resultRDY) c++;
            @(negedge clock);
        end
        check("abort_no_rdy", c, 0);
        run_op("fresh", 32'hFFFF_0000, 5'd16, 1'b1, 32'hFFFF_FFFF, FAST ? 4 : 16, 1'b0);

        // Inputs scrambled every cycle after the start edge.
        run_op("hold", 32'h8000_0000, 5'd12, 1'b1, 32'hFFF8_0000, FAST ? 3 : 12, 1'b1);
        ctrl_start = 1'b0;

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
